// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared opcode constants, IR field positions and sequencer states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [4:0] c_op_add  = 5'b00011;
    localparam logic [4:0] c_op_sub  = 5'b00100;
    localparam logic [4:0] c_op_and  = 5'b00101;
    localparam logic [4:0] c_op_or   = 5'b00110;
    localparam logic [4:0] c_op_shr  = 5'b00111;
    localparam logic [4:0] c_op_shl  = 5'b01000;
    localparam logic [4:0] c_op_ror  = 5'b01001;
    localparam logic [4:0] c_op_rol  = 5'b01010;
    localparam logic [4:0] c_op_mul  = 5'b01111;
    localparam logic [4:0] c_op_div  = 5'b10000;
    localparam logic [4:0] c_op_nop  = 5'b11010;
    localparam logic [4:0] c_op_halt = 5'b11011;

    localparam int c_opc_msb = 31;
    localparam int c_opc_lsb = 27;
    localparam int c_ra_msb  = 26;
    localparam int c_ra_lsb  = 23;
    localparam int c_rb_msb  = 22;
    localparam int c_rb_lsb  = 19;
    localparam int c_rc_msb  = 18;
    localparam int c_rc_lsb  = 15;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    function automatic logic is_alu_op(input logic [4:0] op);
        case (op)
            c_op_add, c_op_sub, c_op_and, c_op_or,
            c_op_shr, c_op_shl, c_op_ror, c_op_rol: is_alu_op = 1'b1;
            default:                                is_alu_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_muldiv_op(input logic [4:0] op);
        is_muldiv_op = (op == c_op_mul) || (op == c_op_div);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_select_decoder.sv
// ============================================================================
// Module : reg_select_decoder
// Brief  : 4-bit register index plus enable to one-hot NREGS select vector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_select_decoder #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       i_idx,
    input  logic             i_en,
    output logic [NREGS-1:0] o_onehot
);

    // Indices beyond NREGS simply match no bit, leaving the vector all-zero.
    for (genvar i = 0; i < NREGS; i++) begin : g_bit
        assign o_onehot[i] = i_en && (int'(i_idx) == i);
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module : control_sequencer
// Brief  : Hardwired Moore control unit driving DataPath strobes per T-state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
    parameter int NREGS = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             stop,
    input  logic [31:0]      IR,
    input  logic             mem_ready,
    output logic [NREGS-1:0] regIn,
    output logic [NREGS-1:0] regOut,
    output logic             HiIn,
    output logic             LoIn,
    output logic             ZIn,
    output logic             PCIn,
    output logic             MDRIn,
    output logic             YIn,
    output logic             MARIn,
    output logic             IRIn,
    output logic             IncPC,
    output logic             HiOut,
    output logic             LoOut,
    output logic             ZHiOut,
    output logic             ZLoOut,
    output logic             PCOut,
    output logic             MDROut,
    output logic             MDRread,
    output logic [4:0]       ALUcode,
    output logic             run,
    output logic             illegal
);

    import cpu_pkg::*;

    state_t      r_state;
    state_t      w_next;
    logic        r_t1_first;
    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_alu;
    logic        w_muldiv;
    logic        w_rin_en;
    logic        w_rout_en;
    logic [3:0]  w_rout_idx;
    state_t      w_boundary;
    logic        w_unused_ir;

    assign w_opcode    = IR[c_opc_msb:c_opc_lsb];
    assign w_ra        = IR[c_ra_msb:c_ra_lsb];
    assign w_rb        = IR[c_rb_msb:c_rb_lsb];
    assign w_rc        = IR[c_rc_msb:c_rc_lsb];
    assign w_unused_ir = ^IR[c_rc_lsb-1:0];
    assign w_alu       = is_alu_op(w_opcode);
    assign w_muldiv    = is_muldiv_op(w_opcode);

    // Every path that would re-enter T0 honours a pending stop request.
    assign w_boundary  = stop ? S_HALT : S_T0;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state    <= S_RESET;
            r_t1_first <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_t1_first <= (w_next == S_T1) && (r_state != S_T1);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_rin_en   = 1'b0;
        w_rout_en  = 1'b0;
        w_rout_idx = w_rc;
        HiIn       = 1'b0;
        LoIn       = 1'b0;
        ZIn        = 1'b0;
        PCIn       = 1'b0;
        MDRIn      = 1'b0;
        YIn        = 1'b0;
        MARIn      = 1'b0;
        IRIn       = 1'b0;
        IncPC      = 1'b0;
        HiOut      = 1'b0;
        LoOut      = 1'b0;
        ZHiOut     = 1'b0;
        ZLoOut     = 1'b0;
        PCOut      = 1'b0;
        MDROut     = 1'b0;
        MDRread    = 1'b0;
        ALUcode    = 5'd0;
        illegal    = 1'b0;
        run        = (r_state != S_RESET) && (r_state != S_HALT);

        case (r_state)
            S_RESET: w_next = w_boundary;
            S_T0: begin
                PCOut  = 1'b1;
                MARIn  = 1'b1;
                IncPC  = 1'b1;
                ZIn    = 1'b1;
                w_next = S_T1;
            end
            S_T1: begin
                ZLoOut  = 1'b1;
                PCIn    = r_t1_first;
                MDRread = 1'b1;
                MDRIn   = 1'b1;
                if (mem_ready) w_next = S_T2;
            end
            S_T2: begin
                MDROut = 1'b1;
                IRIn   = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                if (w_alu || w_muldiv) begin
                    w_rout_en  = 1'b1;
                    w_rout_idx = w_rb;
                    YIn        = 1'b1;
                    w_next     = S_T4;
                end else if (w_opcode == c_op_nop) begin
                    w_next = w_boundary;
                end else if (w_opcode == c_op_halt) begin
                    w_next = S_HALT;
                end else begin
                    illegal = 1'b1;
                    w_next  = w_boundary;
                end
            end
            S_T4: begin
                w_rout_en = 1'b1;
                ZIn       = 1'b1;
                ALUcode   = w_opcode;
                w_next    = S_T5;
            end
            S_T5: begin
                ZLoOut = 1'b1;
                if (w_muldiv) begin
                    LoIn   = 1'b1;
                    w_next = S_T6;
                end else begin
                    w_rin_en = 1'b1;
                    w_next   = w_boundary;
                end
            end
            S_T6: begin
                ZHiOut = 1'b1;
                HiIn   = 1'b1;
                w_next = w_boundary;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RESET;
        endcase
    end

    reg_select_decoder #(.NREGS(NREGS)) u_rin_dec (
        .i_idx    (w_ra),
        .i_en     (w_rin_en),
        .o_onehot (regIn)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_rout_dec (
        .i_idx    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (regOut)
    );

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module : tb_control_sequencer
// Brief  : Directed and random instruction streams against a per-cycle model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic hi_in, lo_in, z_in, pc_in, mdr_in, y_in, mar_in, ir_in, inc_pc;
        logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out;
        logic mdr_read;
        logic [4:0] alu;
        logic run, illegal;
    } ctl_t;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        stop = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        mem_ready = 1'b1;
    logic [15:0] regIn, regOut;
    logic HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, MARIn, IRIn, IncPC;
    logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, MDRread;
    logic [4:0]  ALUcode;
    logic        run, illegal;

    int n_vec = 0;
    int n_err = 0;
    ctl_t obs;

    control_sequencer #(.NREGS(16)) dut (
        .clock(clock), .clear(clear), .stop(stop), .IR(IR), .mem_ready(mem_ready),
        .regIn(regIn), .regOut(regOut),
        .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn),
        .YIn(YIn), .MARIn(MARIn), .IRIn(IRIn), .IncPC(IncPC),
        .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
        .PCOut(PCOut), .MDROut(MDROut), .MDRread(MDRread),
        .ALUcode(ALUcode), .run(run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    assign obs = {regIn, regOut, HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, MARIn, IRIn, IncPC,
                  HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, MDRread, ALUcode, run, illegal};

    always @(negedge clock) begin
        if (!clear) begin
            n_vec++;
            assert ($onehot0({HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut}))
            else begin
                n_err++;
                $error("FAIL bus_excl obs=%b exp=onehot0",
                       {HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut});
            end
        end
    end

    // 0 alu, 1 mul/div, 2 nop, 3 halt, 4 illegal
    function automatic int kind_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: return 0;
            5'b01111, 5'b10000:                     return 1;
            5'b11010:                               return 2;
            5'b11011:                               return 3;
            default:                                return 4;
        endcase
    endfunction

    function automatic ctl_t busy();
        ctl_t e = '0;
        e.run = 1'b1;
        return e;
    endfunction

    task automatic check(input ctl_t e, input string tag);
        n_vec++;
        assert (obs === e)
        else begin
            n_err++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, e);
        end
    endtask

    task automatic do_reset();
        clear = 1'b1;
        stop  = 1'b0;
        #1;
        check('0, "clear_async");
        @(posedge clock); #1;
        check('0, "clear_held");
        clear = 1'b0;
        @(negedge clock);
        check('0, "reset_state");
        @(posedge clock); #1;
    endtask

    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check('0, $sformatf("halt_c%0d", i));
            @(posedge clock); #1;
        end
    endtask

    // Builds the expected per-cycle strobe list for one instruction, then plays it.
    task automatic run_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [3:0] rc, input int waits, input int stop_at,
                             input int abort_at, output bit halted);
        ctl_t q[$];
        ctl_t e;
        int   kind = kind_of(op);

        e = busy(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; q.push_back(e);
        for (int i = 0; i <= waits; i++) begin
            e = busy(); e.zlo_out = 1; e.pc_in = (i == 0); e.mdr_read = 1; e.mdr_in = 1;
            q.push_back(e);
        end
        e = busy(); e.mdr_out = 1; e.ir_in = 1; q.push_back(e);
        e = busy();
        if (kind <= 1) begin
            e.rout = 16'd1 << rb; e.y_in = 1;
        end else if (kind == 4) begin
            e.illegal = 1;
        end
        q.push_back(e);
        if (kind <= 1) begin
            e = busy(); e.rout = 16'd1 << rc; e.z_in = 1; e.alu = op; q.push_back(e);
            e = busy(); e.zlo_out = 1;
            if (kind == 0) e.rin = 16'd1 << ra;
            else           e.lo_in = 1;
            q.push_back(e);
            if (kind == 1) begin
                e = busy(); e.zhi_out = 1; e.hi_in = 1; q.push_back(e);
            end
        end

        halted = (kind == 3) || (stop_at >= 0 && stop_at < q.size());
        IR = {op, ra, rb, rc, 15'($urandom)};
        for (int k = 0; k < q.size(); k++) begin
            if (k >= 1 && k <= waits)  mem_ready = 1'b0;
            else if (k == waits + 1)   mem_ready = 1'b1;
            else                       mem_ready = 1'($urandom);
            stop = (stop_at >= 0 && k >= stop_at);
            @(negedge clock);
            check(q[k], $sformatf("op%b_k%0d", op, k));
            if (k == abort_at) return;
            @(posedge clock); #1;
        end
    endtask

    logic [4:0] legal_ops [12] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                   5'b01001, 5'b01010, 5'b01111, 5'b10000, 5'b11010, 5'b11011};

    initial begin
        bit         h;
        logic [4:0] op;
        int         st;

        do_reset();

        // Clear asserted in the middle of T4 of an add.
        run_instr(5'b00011, 4'd1, 4'd2, 4'd3, 0, -1, 4, h);
        do_reset();

        // or R4,R3,R7 (IR 0x321B8000)
        run_instr(5'b00110, 4'd4, 4'd3, 4'd7, 0, -1, -1, h);
        // Memory stalls three cycles in T1.
        run_instr(5'b00011, 4'd9, 4'd10, 4'd11, 3, -1, -1, h);
        // mul R0,R1,R2
        run_instr(5'b01111, 4'd0, 4'd1, 4'd2, 0, -1, -1, h);
        run_instr(5'b11010, 4'd5, 4'd6, 4'd7, 1, -1, -1, h);
        run_instr(5'b11111, 4'd15, 4'd14, 4'd13, 0, -1, -1, h);
        run_instr(5'b11011, 4'd0, 4'd0, 4'd0, 0, -1, -1, h);
        hold_halt(20);
        do_reset();

        // stop raised during T4 of an add: completes, then halts.
        run_instr(5'b00011, 4'd2, 4'd4, 4'd8, 0, 4, -1, h);
        hold_halt(3);
        do_reset();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) op = 5'($urandom);
            else                           op = legal_ops[$urandom_range(0, 11)];
            st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(op, 4'($urandom), 4'($urandom), 4'($urandom),
                      int'($urandom_range(0, 3)), st, -1, h);
            if (h) begin
                hold_halt(2);
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
